// File: rtl/exe_wb_stage.sv
// Execute stage with WB-to-EXE forwarding, iterative shift-add multiplier,
// and the EXE/WB pipeline register that feeds the register-file write port.
module exe_wb_stage #(
    parameter int unsigned DSIZE = 32,
    parameter int unsigned ASIZE = 5,
    parameter int unsigned SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [2:0]       aluop_cntrl,
    input  logic             alusrc_cntrl,
    input  logic [DSIZE-1:0] rdata1,
    input  logic [DSIZE-1:0] rdata2,
    input  logic [DSIZE-1:0] signextender,
    input  logic [ASIZE-1:0] rs1_addr,
    input  logic [ASIZE-1:0] rs2_addr,
    input  logic [ASIZE-1:0] waddr,
    output logic [DSIZE-1:0] result_out,
    output logic [ASIZE-1:0] waddr_out,
    output logic             wen_out,
    output logic             stall
);

    localparam int unsigned CW = $clog2(DSIZE);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic {IDLE, MUL_BUSY} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [DSIZE-1:0] mcand;
    logic [DSIZE-1:0] mplier;
    logic [DSIZE-1:0] acc;
    logic [ASIZE-1:0] dest;

    logic             fwd_a_hit;
    logic             fwd_b_hit;
    logic [DSIZE-1:0] fwd_a;
    logic [DSIZE-1:0] fwd_b;
    logic [DSIZE-1:0] op_b;
    logic [DSIZE-1:0] alu_res;
    logic [DSIZE-1:0] mul_step;
    logic             last_cnt;
    logic             mul_start;

    // Register r0 is hardwired, so a write to it is never forwarded.
    assign fwd_a_hit = wen_out && (waddr_out == rs1_addr) && (rs1_addr != '0);
    assign fwd_b_hit = wen_out && (waddr_out == rs2_addr) && (rs2_addr != '0);
    assign fwd_a     = fwd_a_hit ? result_out : rdata1;
    assign fwd_b     = fwd_b_hit ? result_out : rdata2;
    assign op_b      = alusrc_cntrl ? signextender : fwd_b;

    assign mul_step  = mplier[0] ? mcand : '0;
    assign last_cnt  = (count == CW'(DSIZE - 1));
    assign mul_start = (state == IDLE) && valid_in && (aluop_cntrl == OP_MUL);

    // Upstream may advance on the final multiply edge, hence no stall there.
    assign stall = !rst && (mul_start || ((state == MUL_BUSY) && !last_cnt));

    always_comb begin
        alu_res = '0;
        case (aluop_cntrl)
            OP_ADD:  alu_res = fwd_a + op_b;
            OP_SUB:  alu_res = fwd_a - op_b;
            OP_AND:  alu_res = fwd_a & op_b;
            OP_OR:   alu_res = fwd_a | op_b;
            OP_XOR:  alu_res = fwd_a ^ op_b;
            OP_SLL:  alu_res = fwd_a << op_b[SHW-1:0];
            OP_SRL:  alu_res = fwd_a >> op_b[SHW-1:0];
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            mcand      <= '0;
            mplier     <= '0;
            acc        <= '0;
            dest       <= '0;
            result_out <= '0;
            waddr_out  <= '0;
            wen_out    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mul_start) begin
                        mcand   <= fwd_a;
                        mplier  <= op_b;
                        acc     <= '0;
                        dest    <= waddr;
                        count   <= '0;
                        wen_out <= 1'b0;
                        state   <= MUL_BUSY;
                    end else if (valid_in) begin
                        result_out <= alu_res;
                        waddr_out  <= waddr;
                        wen_out    <= 1'b1;
                    end else begin
                        wen_out <= 1'b0;
                    end
                end
                MUL_BUSY: begin
                    acc    <= acc + mul_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                    if (last_cnt) begin
                        result_out <= acc + mul_step;
                        waddr_out  <= dest;
                        wen_out    <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        wen_out <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exe_wb_stage.sv
// Self-checking bench for exe_wb_stage: vector table plus scoreboard of
// expected register-file writes, with hand-written multiply/reset sequences.
module tb_exe_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [2:0]  aluop_cntrl;
    logic        alusrc_cntrl;
    logic [31:0] rdata1, rdata2, signextender;
    logic [4:0]  rs1_addr, rs2_addr, waddr;
    logic [31:0] result_out;
    logic [4:0]  waddr_out;
    logic        wen_out;
    logic        stall;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  wa;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [2:0]  op;
        logic        src;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  wa;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[12];

    exe_wb_stage #(.DSIZE(32), .ASIZE(5), .SHW(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .aluop_cntrl  (aluop_cntrl),
        .alusrc_cntrl (alusrc_cntrl),
        .rdata1       (rdata1),
        .rdata2       (rdata2),
        .signextender (signextender),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .waddr        (waddr),
        .result_out   (result_out),
        .waddr_out    (waddr_out),
        .wen_out      (wen_out),
        .stall        (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic src,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] wa);
        valid_in     = v;
        aluop_cntrl  = op;
        alusrc_cntrl = src;
        rdata1       = r1;
        rdata2       = r2;
        signextender = imm;
        rs1_addr     = rs1;
        rs2_addr     = rs2;
        waddr        = wa;
    endtask

    task automatic push(input logic [31:0] res, input logic [4:0] wa);
        exp_t e;
        e.res = res;
        e.wa  = wa;
        sbq.push_back(e);
    endtask

    // Presents a MUL at the current negedge and holds it while stall is high.
    task automatic mul_seq(input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] wa, input logic [31:0] exp);
        int   n;
        logic wen_bad;
        n       = 0;
        wen_bad = 1'b0;
        drive(1'b1, 3'd7, 1'b0, a, b, 32'h0, 5'd0, 5'd0, wa);
        push(exp, wa);
        #1;
        while (stall && n < 100) begin
            n++;
            @(negedge clk);
            #1;
            if (wen_out) wen_bad = 1'b1;
        end
        chk("mul_stall_cycles", 32'(n), 32'd32);
        chk("mul_wen_low_while_busy", {31'd0, wen_bad}, 32'd0);
        @(negedge clk);
    endtask

    // Scoreboard: every write-enable pulse must match the oldest expected write.
    always @(posedge clk) begin
        #1;
        if (wen_out === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_wen_pulse", {27'd0, waddr_out}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_result", result_out, e.res);
                chk("sb_waddr", {27'd0, waddr_out}, {27'd0, e.wa});
            end
        end
    end

    initial begin
        //           op    src   r1            r2            imm           rs1   rs2   wa     exp
        tbl[0]  = '{3'd0, 1'b0, 32'd5,        32'd7,        32'd0,        5'd0, 5'd0, 5'd3,  32'd12};
        tbl[1]  = '{3'd1, 1'b0, 32'd5,        32'd7,        32'd0,        5'd0, 5'd0, 5'd4,  32'hFFFF_FFFE};
        tbl[2]  = '{3'd2, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        5'd0, 5'd0, 5'd5,  32'hF000_F000};
        tbl[3]  = '{3'd3, 1'b0, 32'h0F0F0000, 32'h000000FF, 32'd0,        5'd0, 5'd0, 5'd6,  32'h0F0F_00FF};
        tbl[4]  = '{3'd4, 1'b0, 32'hAAAA5555, 32'hFFFF0000, 32'd0,        5'd0, 5'd0, 5'd7,  32'h5555_5555};
        tbl[5]  = '{3'd5, 1'b1, 32'd1,        32'd0,        32'd31,       5'd0, 5'd0, 5'd8,  32'h8000_0000};
        tbl[6]  = '{3'd6, 1'b0, 32'h80000000, 32'h00000023, 32'd0,        5'd0, 5'd0, 5'd9,  32'h1000_0000};
        tbl[7]  = '{3'd0, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        5'd0, 5'd0, 5'd0,  32'd0};
        tbl[8]  = '{3'd0, 1'b1, 32'd10,       32'd99,       32'hFFFFFFFF, 5'd0, 5'd0, 5'd10, 32'd9};
        tbl[9]  = '{3'd0, 1'b0, 32'd100,      32'd1,        32'd0,        5'd0, 5'd0, 5'd11, 32'd101};
        tbl[10] = '{3'd1, 1'b0, 32'd0,        32'd1,        32'd0,        5'd11, 5'd0, 5'd12, 32'd100};
        tbl[11] = '{3'd4, 1'b0, 32'd5,        32'd0,        32'd0,        5'd0, 5'd12, 5'd13, 32'h0000_0061};

        rst = 1'b1;
        drive(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        repeat (2) @(negedge clk);
        chk("rst_result", result_out, 32'd0);
        chk("rst_waddr", {27'd0, waddr_out}, 32'd0);
        chk("rst_wen", {31'd0, wen_out}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_wen", {31'd0, wen_out}, 32'd0);
        chk("idle_result", result_out, 32'd0);

        for (int i = 0; i < 12; i++) begin
            drive(1'b1, tbl[i].op, tbl[i].src, tbl[i].r1, tbl[i].r2, tbl[i].imm,
                  tbl[i].rs1, tbl[i].rs2, tbl[i].wa);
            push(tbl[i].exp, tbl[i].wa);
            #1;
            chk("alu_no_stall", {31'd0, stall}, 32'd0);
            @(negedge clk);
        end

        // Bubbles: no write, result/destination hold.
        drive(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        repeat (2) @(negedge clk);
        chk("bubble_wen", {31'd0, wen_out}, 32'd0);
        chk("bubble_result_hold", result_out, 32'h0000_0061);
        chk("bubble_waddr_hold", {27'd0, waddr_out}, 32'd13);

        // Forwarding into SLL, then the same with rs1=0 (no forward).
        drive(1'b1, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 5'd0, 5'd0, 5'd3);
        push(32'd12, 5'd3);
        @(negedge clk);
        drive(1'b1, 3'd5, 1'b1, 32'd0, 32'd0, 32'd4, 5'd3, 5'd0, 5'd14);
        push(32'd192, 5'd14);
        @(negedge clk);
        drive(1'b1, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 5'd0, 5'd0, 5'd3);
        push(32'd12, 5'd3);
        @(negedge clk);
        drive(1'b1, 3'd5, 1'b1, 32'd0, 32'd0, 32'd4, 5'd0, 5'd0, 5'd15);
        push(32'd0, 5'd15);
        @(negedge clk);

        // Multiply then a dependent ADD that picks up the product.
        mul_seq(32'h0001_0003, 32'h0000_0005, 5'd20, 32'h0005_000F);
        drive(1'b1, 3'd0, 1'b0, 32'd0, 32'd1, 32'd0, 5'd20, 5'd0, 5'd21);
        push(32'h0005_0010, 5'd21);
        @(negedge clk);
        mul_seq(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd22, 32'h0000_0001);
        drive(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        repeat (2) @(negedge clk);

        // Reset during a busy multiply at count 10: no write may appear.
        drive(1'b1, 3'd7, 1'b0, 32'd3, 32'd7, 32'd0, 5'd0, 5'd0, 5'd23);
        repeat (11) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midmul_rst_stall", {31'd0, stall}, 32'd0);
        chk("midmul_rst_wen", {31'd0, wen_out}, 32'd0);
        chk("midmul_rst_result", result_out, 32'd0);
        chk("midmul_rst_waddr", {27'd0, waddr_out}, 32'd0);
        @(negedge clk);
        drive(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_idle_stall", {31'd0, stall}, 32'd0);
        mul_seq(32'd3, 32'd7, 5'd23, 32'd21);

        // Asynchronous reset between edges clears a freshly written result.
        drive(1'b1, 3'd0, 1'b0, 32'd1, 32'd1, 32'd0, 5'd0, 5'd0, 5'd24);
        push(32'd2, 5'd24);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_result", result_out, 32'd0);
        chk("async_rst_waddr", {27'd0, waddr_out}, 32'd0);
        chk("async_rst_wen", {31'd0, wen_out}, 32'd0);
        @(negedge clk);
        drive(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exe_wb_stage.md
Name: exe_wb_stage

Overview:
Execute stage plus EXE/WB pipeline register of the four-stage pipeline. It consumes the ID/EXE register outputs (ALU op, ALU source select, operands, sign-extended immediate, destination address) and selects operands through WB-to-EXE forwarding. It performs the ALU operation, single-cycle for logic/arith/shift and iterative for MUL, and registers the result, destination and write enable for the register-file write port. A stall output holds the ID/EXE register and earlier stages while a multiply is in progress.

Parameters:
DSIZE, 32, data width (matches `DSIZE)
ASIZE, 5, register address width (matches `ASIZE)
SHW, 5, shift-amount width = log2(DSIZE)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
valid_in  input  1  ID/EXE holds a real instruction
aluop_cntrl  input  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 MUL
alusrc_cntrl  input  1  1: operand B = signextender; 0: forwarded rdata2
rdata1  input  DSIZE  register operand A
rdata2  input  DSIZE  register operand B
signextender  input  DSIZE  sign-extended immediate
rs1_addr  input  ASIZE  source address of A (forwarding compare)
rs2_addr  input  ASIZE  source address of B (forwarding compare)
waddr  input  ASIZE  destination address
result_out  output  DSIZE  EXE/WB result to register-file wdata
waddr_out  output  ASIZE  EXE/WB destination
wen_out  output  1  EXE/WB write enable
stall  output  1  combinational; upstream must hold while 1

Behaviour:
- Reset (asynchronous, any cycle, including mid-MUL): result_out=0, waddr_out=0, wen_out=0, state=IDLE, counter=0, multiply registers=0. stall=0 while rst=1.
- Forwarding: fwdA = (wen_out && waddr_out==rs1_addr && rs1_addr!=0) ? result_out : rdata1. fwdB is the same with rs2_addr/rdata2. Operand B = alusrc_cntrl ? signextender : fwdB.
- Arithmetic: ADD/SUB use modulo 2^DSIZE with no flags. SLL/SRL are logical, with amount B[SHW-1:0]. MUL keeps the low DSIZE bits of the unsigned product.
- State machine: IDLE and MUL_BUSY.
- IDLE with valid_in and op 0-6: at the next edge, result_out=ALU result, waddr_out=waddr, wen_out=1. stall=0. Latency is 1 cycle.
- IDLE with !valid_in: at the next edge, wen_out=0. result_out and waddr_out hold their values.
- IDLE with valid_in and op 7: stall=1 combinationally. At the edge, latch mcand=fwdA, mplier=B, acc=0, dest=waddr, count=0, and go to MUL_BUSY. wen_out=0 at that edge.
- MUL_BUSY: inputs are ignored, because upstream still holds the MUL.
  - Each edge: acc += mplier[0] ? mcand : 0; mcand <<= 1; mplier >>= 1; count++.
  - stall=1 while count<DSIZE-1. wen_out=0 on every busy edge except the last.
  - When count==DSIZE-1: stall=0, so upstream advances on this edge. At this edge result_out = acc + (mplier[0] ? mcand : 0), waddr_out=dest, wen_out=1, state=IDLE.
- MUL timing: the result is visible DSIZE+1 edges after the MUL is first presented. Exactly one wen_out pulse per valid instruction. A new instruction is accepted in the cycle after completion.
- Back-to-back dependents: an instruction directly after an ALU op or a MUL receives the forwarded result with no extra stall.
- rs==0 never forwards. waddr 0 is still written with wen_out=1; the register file ignores r0.
- wen_out is a registered pulse and is never asserted for bubbles.

Test Plan:
- Reset, then no valid_in → result_out=0, waddr_out=0, wen_out=0, stall=0; assert rst mid-cycle → outputs clear without a clock edge.
- ADD rdata1=5, rdata2=7, alusrc=0, waddr=3 → next edge result_out=12, waddr_out=3, wen_out=1; SUB 5-7 → 0xFFFFFFFE.
- Forwarding: ADD r3=12, then next instruction SLL rs1=3 (rdata1=stale 0) with alusrc=1, imm=4 → result_out=192; same sequence with rs1=0 → no forward, result_out=0.
- MUL rdata1=0x0001_0003, rdata2=0x0000_0005 → stall high for 32 cycles (accept cycle plus 31 busy), wen_out low throughout, then result_out=0x0005_000F, wen_out=1 for exactly one cycle; next ADD using rs1=dest gets the forwarded product.
- MUL 0xFFFFFFFF×0xFFFFFFFF → result_out=0x00000001 (low 32 bits).
- Assert rst at busy count=10 → state IDLE, stall=0, no wen_out pulse; re-present the MUL → completes normally.
